regfile_wb_scheduler: RTL and testbench

Write-back scheduler for the 32×32 register file, which has a single write port (WE3/A3/WD3). It arbitrates between the ALU result path and the load-return path from RAM, then drives the register-file write port from a registered stage. It also keeps a per-register pending-load scoreboard that tells decode when a source register is not yet valid.

---
 rtl/regfile_wb_scheduler_if.sv | 48 ++++
 rtl/regfile_wb_scheduler.sv | 111 +++++++++++
 tb/tb_regfile_wb_scheduler.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_scheduler_if.sv
// Bundle of the write-back scheduler's request, scoreboard and register-file
// write-port signals.
//   master : the requesters (ALU, load return, decode) and the register file
//   slave  : regfile_wb_scheduler
interface regfile_wb_scheduler_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic [4:0]  chk_a1;
    logic [4:0]  chk_a2;
    logic        hazard_a1;
    logic        hazard_a2;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  ld_valid, ld_rd, ld_data,
        output ld_ready,
        input  issue_valid, issue_rd,
        output issue_ready,
        input  chk_a1, chk_a2,
        output hazard_a1, hazard_a2,
        output WE3, A3, WD3
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output ld_valid, ld_rd, ld_data,
        input  ld_ready,
        output issue_valid, issue_rd,
        input  issue_ready,
        output chk_a1, chk_a2,
        input  hazard_a1, hazard_a2,
        input  WE3, A3, WD3
    );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler for the single-write-port 32x32 register file.
// Arbitrates ALU results against load returns (load first, ALU after it has
// been starved STARVE_LIMIT cycles), registers the winner onto WE3/A3/WD3,
// and keeps a 2-bit pending-load count per register for decode hazards.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : regfile_wb_scheduler_if.slave (requests, readies, issue/check,
//           hazards, register-file write port)
module regfile_wb_scheduler #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_wb_scheduler_if.slave bus
);

    localparam logic [2:0] STARVE_AGE = 3'(STARVE_LIMIT);

    logic [2:0]  age_q, age_d;
    logic        we3_q, we3_d;
    logic [4:0]  a3_q, a3_d;
    logic [31:0] wd3_q, wd3_d;
    logic [1:0]  cnt_q [32];
    logic [1:0]  cnt_d [32];

    logic        starve;
    logic        alu_grant;
    logic        ld_grant;
    logic        issue_ready;
    logic        issue_fire;
    logic [31:0] inc_vec;
    logic [31:0] dec_vec;

    // Arbitration and write-stage next values
    always_comb begin
        starve    = (age_q >= STARVE_AGE);
        ld_grant  = bus.ld_valid && !(bus.alu_valid && starve);
        alu_grant = bus.alu_valid && !ld_grant;

        age_d = age_q;
        if (!bus.alu_valid || alu_grant) begin
            age_d = 3'd0;
        end else if (age_q != 3'd7) begin
            age_d = age_q + 3'd1;
        end

        we3_d = 1'b0;
        a3_d  = a3_q;
        wd3_d = wd3_q;
        if (ld_grant) begin
            we3_d = (bus.ld_rd != 5'd0);
            a3_d  = bus.ld_rd;
            wd3_d = bus.ld_data;
        end else if (alu_grant) begin
            we3_d = (bus.alu_rd != 5'd0);
            a3_d  = bus.alu_rd;
            wd3_d = bus.alu_data;
        end
    end

    // Pending-load scoreboard. A full counter can still take an issue when a
    // load return to the same register retires in the same cycle.
    always_comb begin
        issue_ready = !((cnt_q[bus.issue_rd] == 2'd3) &&
                        !(ld_grant && (bus.ld_rd == bus.issue_rd)));
        issue_fire  = bus.issue_valid && issue_ready && (bus.issue_rd != 5'd0);
        inc_vec     = issue_fire ? (32'd1 << bus.issue_rd) : 32'd0;
        dec_vec     = ld_grant ? (32'd1 << bus.ld_rd) : 32'd0;

        cnt_d[0] = 2'd0;
        for (int r = 1; r < 32; r++) begin
            cnt_d[r] = cnt_q[r];
            if (inc_vec[r] && !dec_vec[r]) begin
                cnt_d[r] = cnt_q[r] + 2'd1;
            end else if (dec_vec[r] && !inc_vec[r] && (cnt_q[r] != 2'd0)) begin
                cnt_d[r] = cnt_q[r] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_q <= 3'd0;
            we3_q <= 1'b0;
            a3_q  <= 5'd0;
            wd3_q <= 32'd0;
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= 2'd0;
            end
        end else begin
            age_q <= age_d;
            we3_q <= we3_d;
            a3_q  <= a3_d;
            wd3_q <= wd3_d;
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    assign bus.alu_ready   = alu_grant;
    assign bus.ld_ready    = ld_grant;
    assign bus.issue_ready = issue_ready;
    assign bus.hazard_a1   = (cnt_q[bus.chk_a1] != 2'd0);
    assign bus.hazard_a2   = (cnt_q[bus.chk_a2] != 2'd0);
    assign bus.WE3         = we3_q;
    assign bus.A3          = a3_q;
    assign bus.WD3         = wd3_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler. Each granted request pushes the
// expected register-file write into a queue; after the following clock edge
// the entry is popped and compared with WE3/A3/WD3.
module tb_regfile_wb_scheduler;

    typedef struct packed {
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    logic clk;
    logic rst_n;
    int   n_err;
    int   n_chk;
    wr_t  exp_q[$];
    logic [4:0]  exp_a3;
    logic [31:0] exp_wd3;

    regfile_wb_scheduler_if bus();

    regfile_wb_scheduler #(.STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check the readies for the currently driven inputs, queue the expected
    // write, clock once and compare the write port.
    task automatic tick(input string tag, input logic exp_alu, input logic exp_ld);
        wr_t w;
        wr_t got;
        #1;
        chk({tag, ".alu_ready"}, 32'(bus.alu_ready), 32'(exp_alu));
        chk({tag, ".ld_ready"},  32'(bus.ld_ready),  32'(exp_ld));
        if (exp_ld) begin
            w = '{we: (bus.ld_rd != 5'd0), a: bus.ld_rd, d: bus.ld_data};
        end else if (exp_alu) begin
            w = '{we: (bus.alu_rd != 5'd0), a: bus.alu_rd, d: bus.alu_data};
        end else begin
            w = '{we: 1'b0, a: exp_a3, d: exp_wd3};
        end
        exp_a3  = w.a;
        exp_wd3 = w.d;
        exp_q.push_back(w);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        chk({tag, ".WE3"}, 32'(bus.WE3), 32'(got.we));
        chk({tag, ".A3"},  32'(bus.A3),  32'(got.a));
        chk({tag, ".WD3"}, bus.WD3, got.d);
    endtask

    task automatic idle_inputs();
        bus.alu_valid   = 1'b0;
        bus.alu_rd      = 5'd0;
        bus.alu_data    = 32'd0;
        bus.ld_valid    = 1'b0;
        bus.ld_rd       = 5'd0;
        bus.ld_data     = 32'd0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = 5'd0;
        bus.chk_a1      = 5'd0;
        bus.chk_a2      = 5'd0;
    endtask

    initial begin
        logic [31:0] alu_val;
        int          nld;
        logic [9:0]  alu_wins;
        logic [7:0]  alu_wins2;

        n_err   = 0;
        n_chk   = 0;
        exp_a3  = 5'd0;
        exp_wd3 = 32'd0;
        idle_inputs();
        rst_n = 1'b0;

        // Reset state
        #1;
        chk("rst.WE3", 32'(bus.WE3), 32'd0);
        chk("rst.A3", 32'(bus.A3), 32'd0);
        chk("rst.WD3", bus.WD3, 32'd0);
        chk("rst.alu_ready", 32'(bus.alu_ready), 32'd0);
        chk("rst.ld_ready", 32'(bus.ld_ready), 32'd0);
        chk("rst.hazard_a1", 32'(bus.hazard_a1), 32'd0);
        chk("rst.hazard_a2", 32'(bus.hazard_a2), 32'd0);
        chk("rst.issue_ready", 32'(bus.issue_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single ALU write
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd5;
        bus.alu_data  = 32'h1234_5678;
        tick("alu5", 1'b1, 1'b0);
        idle_inputs();
        tick("alu5_after", 1'b0, 1'b0);

        // Starvation: both valid for 10 cycles, ALU wins the 5th and 10th
        alu_wins = 10'b10_0001_0000;
        alu_val  = 32'hA0A0_0001;
        nld      = 0;
        for (int i = 0; i < 10; i++) begin
            bus.alu_valid = 1'b1;
            bus.alu_rd    = 5'd12;
            bus.alu_data  = alu_val;
            bus.ld_valid  = 1'b1;
            bus.ld_rd     = 5'(16 + nld);
            bus.ld_data   = 32'hD000_0000 + 32'(nld);
            tick($sformatf("starve%0d", i), alu_wins[i], !alu_wins[i]);
            if (alu_wins[i]) alu_val = alu_val + 32'd1;
            else             nld++;
        end

        // Age clears when alu_valid drops: 3 L, ld alone, then 4 L before A
        alu_wins2 = 8'b1000_0000;
        for (int i = 0; i < 3; i++) begin
            bus.ld_rd   = 5'(16 + nld);
            bus.ld_data = 32'hD000_0000 + 32'(nld);
            tick($sformatf("agepre%0d", i), 1'b0, 1'b1);
            nld++;
        end
        bus.alu_valid = 1'b0;
        bus.ld_rd     = 5'(16 + nld);
        bus.ld_data   = 32'hD000_0000 + 32'(nld);
        tick("agedrop", 1'b0, 1'b1);
        nld++;
        bus.alu_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.ld_rd   = 5'(16 + nld);
            bus.ld_data = 32'hD000_0000 + 32'(nld);
            tick($sformatf("agepost%0d", i), alu_wins2[i + 3], !alu_wins2[i + 3]);
            if (!alu_wins2[i + 3]) nld++;
        end
        idle_inputs();
        bus.chk_a1 = 5'd16;
        #1;
        chk("sat.hazard_r16", 32'(bus.hazard_a1), 32'd0);

        // Hazard on r7 clears with the load return
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd7;
        bus.chk_a1      = 5'd7;
        #1;
        chk("r7.issue_ready", 32'(bus.issue_ready), 32'd1);
        tick("r7.issue", 1'b0, 1'b0);
        bus.issue_valid = 1'b0;
        #1;
        chk("r7.hazard_set", 32'(bus.hazard_a1), 32'd1);
        bus.ld_valid = 1'b1;
        bus.ld_rd    = 5'd7;
        bus.ld_data  = 32'h0000_00FF;
        tick("r7.ret", 1'b0, 1'b1);
        chk("r7.hazard_clr", 32'(bus.hazard_a1), 32'd0);
        idle_inputs();

        // Three loads to r9 fill its counter
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd9;
        bus.chk_a2      = 5'd9;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("r9.issue%0d_ready", i), 32'(bus.issue_ready), 32'd1);
            tick($sformatf("r9.issue%0d", i), 1'b0, 1'b0);
        end
        #1;
        chk("r9.full_ready", 32'(bus.issue_ready), 32'd0);
        tick("r9.full", 1'b0, 1'b0);
        bus.ld_valid = 1'b1;
        bus.ld_rd    = 5'd9;
        bus.ld_data  = 32'h9999_0001;
        #1;
        chk("r9.bypass_ready", 32'(bus.issue_ready), 32'd1);
        tick("r9.ret_issue", 1'b0, 1'b1);
        bus.ld_valid = 1'b0;
        #1;
        chk("r9.still_full", 32'(bus.issue_ready), 32'd0);
        bus.issue_valid = 1'b0;
        bus.ld_valid    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.ld_data = 32'h9999_0010 + 32'(i);
            #1;
            chk($sformatf("r9.hazard_before%0d", i), 32'(bus.hazard_a2), 32'd1);
            tick($sformatf("r9.ret%0d", i), 1'b0, 1'b1);
        end
        chk("r9.hazard_drained", 32'(bus.hazard_a2), 32'd0);
        idle_inputs();

        // Writes and issues to x0
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd0;
        bus.alu_data  = 32'hDEAD_BEEF;
        tick("x0.alu", 1'b1, 1'b0);
        idle_inputs();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd0;
        #1;
        chk("x0.issue_ready", 32'(bus.issue_ready), 32'd1);
        tick("x0.issue", 1'b0, 1'b0);
        bus.issue_valid = 1'b0;
        bus.chk_a2      = 5'd0;
        #1;
        chk("x0.hazard_a2", 32'(bus.hazard_a2), 32'd0);

        // Reset while r3 has two pending loads and a write is in flight
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd3;
        tick("r3.issue0", 1'b0, 1'b0);
        tick("r3.issue1", 1'b0, 1'b0);
        bus.issue_valid = 1'b0;
        bus.chk_a1      = 5'd3;
        bus.alu_valid   = 1'b1;
        bus.alu_rd      = 5'd4;
        bus.alu_data    = 32'h4444_0004;
        #1;
        chk("r3.hazard_pre", 32'(bus.hazard_a1), 32'd1);
        tick("inflight", 1'b1, 1'b0);
        bus.alu_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst.WE3", 32'(bus.WE3), 32'd0);
        chk("midrst.A3", 32'(bus.A3), 32'd0);
        chk("midrst.WD3", bus.WD3, 32'd0);
        chk("midrst.hazard_r3", 32'(bus.hazard_a1), 32'd0);
        chk("midrst.issue_ready", 32'(bus.issue_ready), 32'd1);
        exp_a3  = 5'd0;
        exp_wd3 = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd6;
        bus.alu_data  = 32'h6666_0006;
        tick("post_rst", 1'b1, 1'b0);
        idle_inputs();
        bus.chk_a1 = 5'd3;
        tick("post_rst_idle", 1'b0, 1'b0);
        chk("post_rst.hazard_r3", 32'(bus.hazard_a1), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
